fetch_queue: RTL

//   Instruction prefetch unit directly upstream of decode/register-read. Owns the PC, drives memory

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    localparam int          INSTR_W  = 16;
    localparam int          PC_W     = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // PC arithmetic is 16-bit modulo, so FFFE steps to 0000.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: small synchronous FIFO with async reset; flush wins over push and pop.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push_s;
    logic         do_pop_s;

    // Pointers are one bit wider than the index so full and empty differ.
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Pointer next-state with flush priority.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            do_push_s = push & (count != FULL);
            do_pop_s  = pop & (count != '0);
            if (do_push_s) begin
                wptr_d = wptr_q + (AW+1)'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + (AW+1)'(1);
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, fetch issue with credit check, in-flight slot and output FIFO.
// Define FETCH_BYPASS_EN to present a return directly to decode when the FIFO is empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] PC_RESET = RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] mem_raddr,
    output logic        mem_issue,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] infl_pc_q, infl_pc_d;
    logic            infl_v_q, infl_v_d;
    logic [CW-1:0]   count_s;
    logic [CW:0]     credit_s;
    logic [31:0]     fifo_rdata_s;
    fq_entry_t       head_s;
    fq_entry_t       ret_s;
    logic            ret_v_s;
    logic            fifo_v_s;
    logic            bypass_hit_s;
    logic            push_s;
    logic            pop_s;
    logic            unused_s;

    // Credit ignores a same-cycle pop, so a push can never meet a full FIFO.
    assign credit_s  = {1'b0, count_s} + {{CW{1'b0}}, infl_v_q};
    assign mem_issue = ~reset & ~redirect & ~halt & (credit_s < (CW+1)'(DEPTH));
    assign mem_raddr = pc_q[15:1];
    assign unused_s  = redirect_pc[0];

    assign ret_v_s  = infl_v_q & ~redirect;
    assign ret_s    = '{pc: infl_pc_q, instr: mem_rdata};
    assign fifo_v_s = (count_s != '0);
    assign head_s   = fifo_rdata_s;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit_s = ret_v_s & ~fifo_v_s;
`else
    assign bypass_hit_s = 1'b0;
`endif

    assign push_s = ret_v_s & ~(bypass_hit_s & out_ready);
    assign pop_s  = fifo_v_s & out_ready;

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push_s),
        .wdata (ret_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .count (count_s)
    );

    // Decode-facing outputs; zero whenever nothing valid is presented.
    always_comb begin
        out_valid = 1'b0;
        out_instr = 16'h0000;
        out_pc    = 16'h0000;
        if (fifo_v_s) begin
            out_valid = 1'b1;
            out_instr = head_s.instr;
            out_pc    = head_s.pc;
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass_hit_s) begin
            out_valid = 1'b1;
            out_instr = mem_rdata;
            out_pc    = infl_pc_q;
        end
`endif
        else begin
            out_valid = 1'b0;
            out_instr = 16'h0000;
            out_pc    = 16'h0000;
        end
    end

    // PC and in-flight next-state; redirect discards the pending return.
    always_comb begin
        pc_d      = pc_q;
        infl_v_d  = infl_v_q;
        infl_pc_d = infl_pc_q;
        if (redirect) begin
            pc_d     = {redirect_pc[15:1], 1'b0};
            infl_v_d = 1'b0;
        end else if (mem_issue) begin
            pc_d      = next_pc(pc_q);
            infl_v_d  = 1'b1;
            infl_pc_d = pc_q;
        end else begin
            infl_v_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= PC_RESET;
            infl_v_q  <= 1'b0;
            infl_pc_q <= 16'h0000;
        end else begin
            pc_q      <= pc_d;
            infl_v_q  <= infl_v_d;
            infl_pc_q <= infl_pc_d;
        end
    end

endmodule
